ex_stage: RTL and testbench

- Execute stage of the 32-bit RISC-V pipeline, with the EX/MEM pipeline register.
- A combinational ALU operates on r_data1 and a selected second operand (r_data2 or the sign-extended immediate).
- The result, the forwarded store data, the destination field, PC+4 and the remaining control bits are registered into the MEM stage on each rising clock edge.

---
 rtl/ex_stage.sv | 75 +++++++
 tb/tb_ex_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 32-bit RISC-V pipeline together with the EX/MEM register.
// A combinational ALU feeds the register. Store data, destination field, PC+4
// and the MEM/WB control bits pass through the same register.
module ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  ctrl_ex,
    input  logic [31:0] rd_ex,
    input  logic [31:0] pc4_ex,
    input  logic [31:0] r_data1,
    input  logic [31:0] r_data2,
    input  logic [31:0] extended,
    output logic [4:0]  ctrl_mem,
    output logic [31:0] rd_mem,
    output logic [31:0] pc4_mem,
    output logic [31:0] alu_result,
    output logic [31:0] write_data1
);

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEMCTRL_W = 5;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned SHAMT_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SLL = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;

    logic [OP_W-1:0]    alu_op_c;
    logic               alu_src_c;
    logic [DATA_W-1:0]  operand_b_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [DATA_W-1:0]  alu_c;

    assign alu_op_c  = ctrl_ex[3:1];
    assign alu_src_c = ctrl_ex[0];

    // Operand B mux and ALU; reserved opcodes produce zero
    always_comb begin
        operand_b_c = alu_src_c ? extended : r_data2;
        shamt_c     = operand_b_c[SHAMT_W-1:0];
        alu_c       = '0;
        case (alu_op_c)
            OP_ADD:  alu_c = r_data1 + operand_b_c;
            OP_SUB:  alu_c = r_data1 - operand_b_c;
            OP_AND:  alu_c = r_data1 & operand_b_c;
            OP_OR:   alu_c = r_data1 | operand_b_c;
            OP_SLL:  alu_c = r_data1 << shamt_c;
            OP_SLT:  alu_c = ($signed(r_data1) < $signed(operand_b_c))
                             ? DATA_W'(1) : DATA_W'(0);
            default: alu_c = '0;
        endcase
    end

    // EX/MEM pipeline register, loads every cycle, synchronous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_mem    <= '0;
            rd_mem      <= '0;
            pc4_mem     <= '0;
            alu_result  <= '0;
            write_data1 <= '0;
        end else begin
            ctrl_mem    <= ctrl_ex[8:8-MEMCTRL_W+1];
            rd_mem      <= rd_ex;
            pc4_mem     <= pc4_ex;
            alu_result  <= alu_c;
            write_data1 <= r_data2;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: the driver pushes expected EX/MEM contents,
// and the monitor pops and compares them just after each rising edge.
module tb_ex_stage;

    logic        clk;
    logic        reset_n;
    logic [8:0]  ctrl_ex;
    logic [31:0] rd_ex, pc4_ex, r_data1, r_data2, extended;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;

    typedef struct {
        logic [4:0]  ctrl;
        logic [31:0] rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   issued = 0;
    int   popped = 0;

    ex_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ctrl_ex     (ctrl_ex),
        .rd_ex       (rd_ex),
        .pc4_ex      (pc4_ex),
        .r_data1     (r_data1),
        .r_data2     (r_data2),
        .extended    (extended),
        .ctrl_mem    (ctrl_mem),
        .rd_mem      (rd_mem),
        .pc4_mem     (pc4_mem),
        .alu_result  (alu_result),
        .write_data1 (write_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU computed from the instruction semantics with wide integer arithmetic
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned shifted;
        longint          r;
        case (op)
            3'd0: r = sa + sb;
            3'd1: r = sa - sb;
            3'd2: r = longint'(a & b);
            3'd3: r = longint'(a | b);
            3'd4: begin
                shifted = ua * (64'd1 << (b % 32));
                r = longint'(shifted);
            end
            3'd5: r = (sa < sb) ? 1 : 0;
            default: r = 0;
        endcase
        return 32'(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the register must hold after the next edge
    task automatic drive(input logic rst, input logic [4:0] mctl, input logic [2:0] op,
                         input logic src, input logic [31:0] rd, input logic [31:0] pc4,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        @(negedge clk);
        reset_n  = rst;
        ctrl_ex  = {mctl, op, src};
        rd_ex    = rd;
        pc4_ex   = pc4;
        r_data1  = a;
        r_data2  = b;
        extended = imm;
        if (!rst) begin
            e.ctrl = '0; e.rd = '0; e.pc4 = '0; e.alu = '0; e.wd = '0;
        end else begin
            e.ctrl = mctl;
            e.rd   = rd;
            e.pc4  = pc4;
            e.alu  = ref_alu(op, a, src ? imm : b);
            e.wd   = b;
        end
        exp_q.push_back(e);
        issued++;
    endtask

    task automatic op_case(input logic [2:0] op, input logic src, input logic [31:0] a,
                           input logic [31:0] b_or_imm);
        logic [31:0] other = $urandom;
        if (src)
            drive(1'b1, 5'($urandom), op, 1'b1, $urandom, $urandom, a, other, b_or_imm);
        else
            drive(1'b1, 5'($urandom), op, 1'b0, $urandom, $urandom, a, b_or_imm, other);
    endtask

    // Monitor: every rising edge presents a new register value
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            check("ctrl_mem",    32'(ctrl_mem), 32'(e.ctrl));
            check("rd_mem",      rd_mem,        e.rd);
            check("pc4_mem",     pc4_mem,       e.pc4);
            check("alu_result",  alu_result,    e.alu);
            check("write_data1", write_data1,   e.wd);
        end
    end

    initial begin
        reset_n = 1'b0; ctrl_ex = '0; rd_ex = '0; pc4_ex = '0;
        r_data1 = '0; r_data2 = '0; extended = '0;

        drive(1'b0, 5'h1f, 3'd0, 1'b0, 32'hdead_beef, 32'h1234, 32'h5, 32'h7, 32'h9);
        drive(1'b0, 5'h0a, 3'd1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);

        // Pass-through with all ones, then all zeros
        drive(1'b1, 5'b11111, 3'b000, 1'b0, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 32'hffff_ffff, 32'h0);
        drive(1'b1, 5'b00000, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // ADD / SUB
        op_case(3'd0, 1'b0, 32'd1073741823, 32'd1);
        op_case(3'd0, 1'b1, 32'(-70), 32'd5);
        op_case(3'd1, 1'b0, 32'd1073741824, 32'd1);
        op_case(3'd1, 1'b1, 32'd81, 32'd970);
        op_case(3'd0, 1'b0, 32'hffff_ffff, 32'd1);
        // AND / OR
        op_case(3'd2, 1'b0, 32'hcccc_cccc, 32'haaaa_aaaa);
        op_case(3'd2, 1'b1, 32'h3333_3333, 32'h5555_5555);
        op_case(3'd3, 1'b0, 32'hcccc_cccc, 32'haaaa_aaaa);
        op_case(3'd3, 1'b1, 32'h3333_3333, 32'h5555_5555);
        // SLL including upper shift bits ignored
        op_case(3'd4, 1'b0, 32'haaaa_aaaa, 32'd1);
        op_case(3'd4, 1'b1, 32'h5555_5555, 32'd2);
        op_case(3'd4, 1'b0, 32'haaaa_aaaa, 32'h21);
        op_case(3'd4, 1'b0, 32'h0000_0001, 32'd31);
        // SLT signed
        op_case(3'd5, 1'b0, 32'd10, 32'd80);
        op_case(3'd5, 1'b0, 32'(-10), 32'(-10));
        op_case(3'd5, 1'b0, 32'd10, 32'(-105));
        op_case(3'd5, 1'b1, 32'(-87), 32'd105);
        op_case(3'd5, 1'b1, 32'd87, 32'd87);
        op_case(3'd5, 1'b1, 32'(-87), 32'(-287));
        op_case(3'd5, 1'b0, 32'h8000_0000, 32'h0);
        // Reserved opcodes
        op_case(3'd6, 1'b0, 32'h1234_5678, 32'h1111_1111);
        op_case(3'd7, 1'b1, 32'hffff_ffff, 32'hffff_ffff);

        // Mid-stream reset with nonzero inputs, then resume
        drive(1'b0, 5'h15, 3'd0, 1'b0, 32'hffff_0000, 32'h0000_ffff, 32'h10, 32'h20, 32'h30);
        drive(1'b1, 5'h15, 3'd0, 1'b0, 32'hffff_0000, 32'h0000_ffff, 32'h10, 32'h20, 32'h30);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, imm;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            drive(($urandom_range(0, 29) != 0), 5'($urandom), 3'($urandom), 1'($urandom),
                  $urandom, $urandom, a, b, imm);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("drained", 32'(popped), 32'(issued));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
